pramp: RTL

Position ramp generator: produces a 32-bit position word that starts at a programmed value and steps up or down by a fixed increment every PERIOD clocks, for NUM steps or indefinitely. It is the source end of the position bus that pcomp and the other position consumers sample on posn_i. It lets position-compare chains run on hardware without an encoder and gives benches a synthesisable stimulus. One instance sits on the position bus, and its posn_o is routed like any encoder output.

---
 rtl/pramp_pkg.sv | 17 +
 rtl/pramp.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pramp_pkg.sv
`default_nettype none
// ============================================================================
// pramp_pkg : shared types and constants for the position ramp generator
// Rev 1.0
// ============================================================================
package pramp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ERR_PERIOD_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/pramp.sv
`default_nettype none
// ============================================================================
// pramp : 32-bit position ramp generator driving the position bus
// Rev 1.0
// ============================================================================
module pramp
  import pramp_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [31:0] START,
  input  logic [31:0] STEP,
  input  logic [31:0] PERIOD,
  input  logic [31:0] NUM,
  input  logic        DIR,
  output logic [31:0] posn_o,
  output logic        strobe_o,
  output logic        act_o,
  output logic [31:0] err_o
);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_enable_q;
  logic [31:0] r_step;
  logic [31:0] r_period;
  logic [31:0] r_num;
  logic        r_dir;
  logic [31:0] r_pcnt;
  logic [31:0] r_scnt;
  logic [31:0] r_posn;
  logic        r_strobe;
  logic        r_act;
  logic        r_err_pzero;

  logic        w_rise;
  logic        w_period_ok;
  logic        w_tick;
  logic        w_last;
  logic        w_load;
  logic        w_perr;
  logic        w_update;
  logic [31:0] w_posn_nxt;

  assign w_rise      = enable_i & ~r_enable_q;
  assign w_period_ok = (PERIOD != 32'd0);
  assign w_tick      = (r_pcnt == (r_period - 32'd1));
  assign w_last      = (r_num != 32'd0) && ((r_scnt + 32'd1) == r_num);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise && w_period_ok) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // An enable fall wins over a final step landing on the same edge
        if (!enable_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!enable_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load     = (r_state == ST_IDLE) && w_rise && w_period_ok;
    w_perr     = (r_state == ST_IDLE) && w_rise && !w_period_ok;
    w_update   = (r_state == ST_RUN) && enable_i && w_tick;
    w_posn_nxt = r_dir ? (r_posn - r_step) : (r_posn + r_step);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // Enable held high through reset must not look like a fresh start
      r_enable_q  <= 1'b1;
      r_step      <= 32'd0;
      r_period    <= 32'd0;
      r_num       <= 32'd0;
      r_dir       <= 1'b0;
      r_pcnt      <= 32'd0;
      r_scnt      <= 32'd0;
      r_posn      <= 32'd0;
      r_strobe    <= 1'b0;
      r_act       <= 1'b0;
      r_err_pzero <= 1'b0;
    end else begin
      r_enable_q <= enable_i;
      r_strobe   <= w_load | w_update;
      r_act      <= (w_state_nxt == ST_RUN);
      if (w_load) begin
        r_step      <= STEP;
        r_period    <= PERIOD;
        r_num       <= NUM;
        r_dir       <= DIR;
        r_posn      <= START;
        r_pcnt      <= 32'd0;
        r_scnt      <= 32'd0;
        r_err_pzero <= 1'b0;
      end else if (w_perr) begin
        r_err_pzero <= 1'b1;
      end else if ((r_state == ST_RUN) && enable_i) begin
        if (w_tick) begin
          r_pcnt <= 32'd0;
          r_posn <= w_posn_nxt;
          r_scnt <= r_scnt + 32'd1;
        end else begin
          r_pcnt <= r_pcnt + 32'd1;
        end
      end
    end
  end

  assign posn_o   = r_posn;
  assign strobe_o = r_strobe;
  assign act_o    = r_act;

  always_comb begin
    err_o                  = 32'd0;
    err_o[ERR_PERIOD_ZERO] = r_err_pzero;
  end

endmodule
`default_nettype wire
